// File: rtl/register_file_sb.sv
// rtl/register_file_sb.sv - multi-port register file with integrated busy-bit scoreboard
// Optional same-cycle write-to-read bypass under `REGFILE_BYPASS_EN.
module register_file_sb #(
  parameter int REG_W     = 32,
  parameter int REG_COUNT = 32,
  parameter int RD_PORTS  = 2,
  parameter int WR_PORTS  = 2,
  localparam int REG_IDX_W = $clog2(REG_COUNT)
) (
  input  logic                          clk,
  input  logic                          aresetn,
  input  logic [RD_PORTS*REG_IDX_W-1:0] rd_reg,
  output logic [RD_PORTS*REG_W-1:0]     rd_data,
  output logic [RD_PORTS-1:0]           rd_busy,
  input  logic [WR_PORTS-1:0]           wr_en,
  input  logic [WR_PORTS*REG_IDX_W-1:0] wr_reg,
  input  logic [WR_PORTS*REG_W-1:0]     wr_data,
  input  logic                          rsv_en,
  input  logic [REG_IDX_W-1:0]          rsv_reg,
  output logic [REG_COUNT-1:0]          busy
);

  // Register 0 has neither data nor busy storage.
  logic [REG_W-1:0]     regs_q [REG_COUNT-1:1];
  logic [REG_W-1:0]     regs_d [REG_COUNT-1:1];
  logic [REG_COUNT-1:1] busy_q;
  logic [REG_COUNT-1:1] busy_d;

  // Later ports overwrite earlier ones, so the highest enabled port wins.
  // The reserve is applied last so a new producer outranks a completing one.
  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    for (int k = 0; k < WR_PORTS; k++) begin
      for (int i = 1; i < REG_COUNT; i++) begin
        if (wr_en[k] && (wr_reg[k*REG_IDX_W +: REG_IDX_W] == REG_IDX_W'(i))) begin
          regs_d[i] = wr_data[k*REG_W +: REG_W];
          busy_d[i] = 1'b0;
        end
      end
    end
    for (int i = 1; i < REG_COUNT; i++) begin
      if (rsv_en && (rsv_reg == REG_IDX_W'(i))) begin
        busy_d[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      for (int i = 1; i < REG_COUNT; i++) begin
        regs_q[i] <= '0;
      end
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end

  assign busy = {busy_q, 1'b0};

  for (genvar gp = 0; gp < RD_PORTS; gp++) begin : g_rd
    logic [REG_IDX_W-1:0] idx;
    logic [REG_W-1:0]     data;
    logic                 bsy;

    assign idx = rd_reg[gp*REG_IDX_W +: REG_IDX_W];

    always_comb begin
      data = '0;
      bsy  = 1'b0;
      for (int i = 1; i < REG_COUNT; i++) begin
        if (idx == REG_IDX_W'(i)) begin
          data = regs_q[i];
          bsy  = busy_q[i];
        end
      end
`ifdef REGFILE_BYPASS_EN
      // Gated by aresetn so reads stay zero while the file is held in reset.
      for (int k = 0; k < WR_PORTS; k++) begin
        if (aresetn && (idx != '0) && wr_en[k] &&
            (wr_reg[k*REG_IDX_W +: REG_IDX_W] == idx)) begin
          data = wr_data[k*REG_W +: REG_W];
          bsy  = rsv_en && (rsv_reg == idx);
        end
      end
`endif
    end

    assign rd_data[gp*REG_W +: REG_W] = data;
    assign rd_busy[gp]                = bsy;
  end

endmodule
